// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding imem requests,
// one-entry response buffer and a registered IF/ID slot feeding decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_next_s;
    logic [31:0] req_pc_r;
    logic [31:0] req_pc_next_s;
    logic [31:0] resp_buf_r;
    logic [31:0] resp_buf_next_s;
    logic        slot_valid_r;
    logic [31:0] slot_pc_r;
    logic [31:0] slot_insn_r;
    logic        slot_free_s;
    logic        load_s;
    logic [31:0] load_insn_s;
    logic [31:0] redirect_target_s;
    logic        req_fire_s;

    assign redirect_target_s = {redirect_pc[31:2], 2'b00};
    assign slot_free_s       = !slot_valid_r || !stall;
    assign imem_req_valid    = (state_r == ST_REQ) && !redirect_valid && !reset;
    assign imem_req_addr     = fetch_pc_r;
    assign req_fire_s        = imem_req_valid && imem_req_ready;

    assign if_id_valid       = slot_valid_r;
    assign if_id_pc          = slot_pc_r;
    assign if_id_instruction = slot_insn_r;

    // Next-state, next-PC, buffer capture and slot-load decision.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        req_pc_next_s   = req_pc_r;
        resp_buf_next_s = resp_buf_r;
        load_s          = 1'b0;
        load_insn_s     = resp_buf_r;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_next_s = redirect_target_s;
                end else if (req_fire_s) begin
                    req_pc_next_s   = fetch_pc_r;
                    fetch_pc_next_s = fetch_pc_r + 32'd4;
                    state_next_s    = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    // A response landing with the redirect belongs to the old path.
                    fetch_pc_next_s = redirect_target_s;
                    state_next_s    = imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (imem_resp_valid) begin
                    if (slot_free_s) begin
                        load_s       = 1'b1;
                        load_insn_s  = imem_resp_data;
                        state_next_s = ST_REQ;
                    end else begin
                        resp_buf_next_s = imem_resp_data;
                        state_next_s    = ST_FULL;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_FULL: begin
                if (redirect_valid) begin
                    fetch_pc_next_s = redirect_target_s;
                    state_next_s    = ST_REQ;
                end else if (!stall) begin
                    load_s       = 1'b1;
                    load_insn_s  = resp_buf_r;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    fetch_pc_next_s = redirect_target_s;
                end else begin
                    fetch_pc_next_s = fetch_pc_r;
                end
                if (imem_resp_valid) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_REQ;
            end
        endcase
    end

    // Fetch-side state: FSM, PCs and response buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_REQ;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
            resp_buf_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            req_pc_r   <= req_pc_next_s;
            resp_buf_r <= resp_buf_next_s;
        end
    end

    // IF/ID slot: flush beats load, and a consumed slot empties to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_r <= 1'b0;
            slot_pc_r    <= 32'h0000_0000;
            slot_insn_r  <= BUBBLE_INSN;
        end else if (redirect_valid) begin
            slot_valid_r <= 1'b0;
            slot_insn_r  <= BUBBLE_INSN;
        end else if (load_s) begin
            slot_valid_r <= 1'b1;
            slot_pc_r    <= req_pc_r;
            slot_insn_r  <= load_insn_s;
        end else if (!stall) begin
            slot_valid_r <= 1'b0;
            slot_insn_r  <= BUBBLE_INSN;
        end else begin
            slot_valid_r <= slot_valid_r;
            slot_pc_r    <= slot_pc_r;
            slot_insn_r  <= slot_insn_r;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; every expected
// value below is hand-derived from the cycle-by-cycle fetch behaviour.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BUBBLE = 32'h0000_0013;
    localparam logic [31:0] W0 = 32'h1111_0001;
    localparam logic [31:0] W1 = 32'h2222_0002;
    localparam logic [31:0] W2 = 32'h3333_0003;
    localparam logic [31:0] W3 = 32'h4444_0004;
    localparam logic [31:0] W4 = 32'h5555_0005;
    localparam logic [31:0] W5 = 32'h6666_0006;
    localparam logic [31:0] W6 = 32'h7777_0007;
    localparam logic [31:0] W7 = 32'h8888_0008;
    localparam logic [31:0] W8 = 32'h9999_0009;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] insn);
        check_val({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
        if (v) check_val({tag, "_pc"}, if_id_pc, pc);
        check_val({tag, "_insn"}, if_id_instruction, insn);
    endtask

    task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
        #1;
        check_val({tag, "_req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
        if (v) check_val({tag, "_req_addr"}, imem_req_addr, addr);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        cyc(); cyc();
        // Reset state
        check_slot("rst", 1'b0, 32'd0, BUBBLE);
        check_val("rst_pc", if_id_pc, 32'd0);
        check_req("rst", 1'b0, 32'd0);

        // Free-running fetch, single-cycle response
        reset = 1'b0; imem_req_ready = 1'b1;
        check_req("first", 1'b1, 32'h0000_0000);
        cyc();
        check_req("wait0", 1'b0, 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = W0;
        cyc();
        check_slot("slot0", 1'b1, 32'h0, W0);
        imem_resp_valid = 1'b0;
        check_req("req4", 1'b1, 32'h4);
        cyc();
        check_slot("bubble", 1'b0, 32'h0, BUBBLE);
        imem_resp_valid = 1'b1; imem_resp_data = W1;
        cyc();
        check_slot("slot1", 1'b1, 32'h4, W1);
        imem_resp_valid = 1'b0;
        check_req("req8", 1'b1, 32'h8);

        // Stall for three cycles while a response arrives
        stall = 1'b1;
        cyc();
        check_slot("stall_hold0", 1'b1, 32'h4, W1);
        imem_resp_valid = 1'b1; imem_resp_data = W2;
        cyc();
        check_slot("stall_hold1", 1'b1, 32'h4, W1);
        imem_resp_valid = 1'b0;
        check_req("full_noreq", 1'b0, 32'd0);
        cyc();
        check_slot("stall_hold2", 1'b1, 32'h4, W1);
        stall = 1'b0;
        cyc();
        check_slot("buf_load", 1'b1, 32'h8, W2);
        check_req("req12", 1'b1, 32'hC);

        // Redirect while waiting; response arrives two cycles later and is dropped
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        check_req("redir_noreq", 1'b0, 32'd0);
        cyc();
        check_slot("redir_flush", 1'b0, 32'h0, BUBBLE);
        redirect_valid = 1'b0;
        check_req("drop_noreq", 1'b0, 32'd0);
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = W3;
        cyc();
        imem_resp_valid = 1'b0;
        check_slot("dropped", 1'b0, 32'h0, BUBBLE);
        check_req("req100", 1'b1, 32'h100);

        // Redirect and response in the same waiting cycle
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        imem_resp_valid = 1'b1; imem_resp_data = W4;
        cyc();
        redirect_valid = 1'b0; imem_resp_valid = 1'b0;
        check_slot("samecyc", 1'b0, 32'h0, BUBBLE);
        check_req("req200", 1'b1, 32'h200);

        // Redirect with stall and a valid slot
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = W5;
        cyc();
        imem_resp_valid = 1'b0;
        check_slot("slot200", 1'b1, 32'h200, W5);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        check_req("redir_stall_noreq", 1'b0, 32'd0);
        cyc();
        check_slot("stall_flush", 1'b0, 32'h0, BUBBLE);
        redirect_valid = 1'b0; stall = 1'b0;
        check_req("req300", 1'b1, 32'h300);

        // Wrap-around of the fetch address
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect_valid = 1'b0;
        check_req("reqtop", 1'b1, 32'hFFFF_FFFC);
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = W6;
        cyc();
        imem_resp_valid = 1'b0;
        check_slot("slottop", 1'b1, 32'hFFFF_FFFC, W6);
        check_req("wrap", 1'b1, 32'h0);

        // Reset asserted while a response sits in the buffer
        stall = 1'b1;
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = W7;
        cyc();
        imem_resp_valid = 1'b0;
        check_req("full2_noreq", 1'b0, 32'd0);
        reset = 1'b1;
        check_req("rst_mid_noreq", 1'b0, 32'd0);
        cyc();
        check_slot("rst_mid", 1'b0, 32'h0, BUBBLE);
        check_val("rst_mid_pc", if_id_pc, 32'd0);
        reset = 1'b0; stall = 1'b0;
        check_req("rst_refetch", 1'b1, 32'h0);

        // Stray response after reset must not reach the slot
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = W8;
        cyc();
        imem_resp_valid = 1'b0;
        check_slot("stray", 1'b0, 32'h0, BUBBLE);
        check_req("stray_req", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
